// File: rtl/dottori_scandoubler.sv
// Scan doubler: ping-pong line buffers replay each source line twice at 2x the pixel rate.
// Optional feature macro DOTTORI_SCANLINES_EN blanks the colour of every repeated (rep=1) line.
module dottori_scandoubler #(
  parameter int LINE_LEN = 256,
  parameter int HS_WIDTH = 16
) (
  input  logic CLK_8M,
  input  logic RESET,
  input  logic PIX_CE,
  input  logic RED,
  input  logic GREEN,
  input  logic BLUE,
  input  logic H_SYNC,
  input  logic V_SYNC,
  input  logic H_BLANK,
  input  logic V_BLANK,
  output logic VGA_R,
  output logic VGA_G,
  output logic VGA_B,
  output logic VGA_HS,
  output logic VGA_VS,
  output logic VGA_BLANK,
  output logic LOCKED
);

  localparam logic [7:0] X_LAST = 8'(LINE_LEN - 1);
  localparam logic [8:0] HS_LIM = 9'(HS_WIDTH);

  // Entry layout {BLANK, B, G, R}
  logic [3:0] line_mem [2][LINE_LEN];

  logic       hs_prev;
  logic       hedge;
  logic       wr_en;
  logic [3:0] wr_data;
  logic [7:0] in_x;
  logic       in_full;
  logic       wsel;
  logic [7:0] out_x;
  logic       rep;
  logic       vs_cap;
  logic       vs_out;
  logic       locked;

  logic [3:0] rd_p0;
  logic [7:0] x_p0;
  logic       vs_p0;
  logic       locked_p0;
  logic       hs_p0;
  logic       blank_p0;
  logic [2:0] rgb_p0;
`ifdef DOTTORI_SCANLINES_EN
  logic       rep_p0;
`endif

  assign hedge   = PIX_CE & H_SYNC & ~hs_prev;
  assign wr_en   = PIX_CE & ~hedge & locked & ~in_full;
  assign wr_data = {H_BLANK | V_BLANK, BLUE, GREEN, RED};
  assign LOCKED  = locked;

  always_ff @(posedge CLK_8M) begin
    if (RESET) begin
      hs_prev   <= 1'b0;
      in_x      <= '0;
      in_full   <= 1'b0;
      wsel      <= 1'b0;
      out_x     <= '0;
      rep       <= 1'b0;
      vs_cap    <= 1'b0;
      vs_out    <= 1'b0;
      locked    <= 1'b0;
      locked_p0 <= 1'b0;
    end else begin
      locked_p0 <= locked;
      if (PIX_CE) hs_prev <= H_SYNC;
      // A source line start beats both the write counter and any read-side wrap
      if (hedge) begin
        in_x    <= '0;
        in_full <= 1'b0;
        wsel    <= ~wsel;
        out_x   <= '0;
        rep     <= 1'b0;
        vs_out  <= vs_cap;
        vs_cap  <= V_SYNC;
        locked  <= 1'b1;
      end else begin
        if (wr_en) begin
          if (in_x == X_LAST) in_full <= 1'b1;
          else                in_x    <= in_x + 8'd1;
        end
        if (out_x == X_LAST) begin
          out_x <= '0;
          rep   <= ~rep;
        end else begin
          out_x <= out_x + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK_8M) begin
    if (wr_en) line_mem[wsel][in_x] <= wr_data;
  end

  // Stage p0: buffer read, with position and sync state carried alongside
  always_ff @(posedge CLK_8M) begin
    rd_p0  <= line_mem[~wsel][out_x];
    x_p0   <= out_x;
    vs_p0  <= vs_out;
`ifdef DOTTORI_SCANLINES_EN
    rep_p0 <= rep;
`endif
  end

  always_comb begin
    hs_p0    = ({1'b0, x_p0} < HS_LIM);
    blank_p0 = rd_p0[3] | hs_p0;
    rgb_p0   = blank_p0 ? 3'b000 : rd_p0[2:0];
`ifdef DOTTORI_SCANLINES_EN
    if (rep_p0) rgb_p0 = 3'b000;
`endif
  end

  // Stage p1: output register, held at the idle pattern until the first line start
  always_ff @(posedge CLK_8M) begin
    if (RESET || !locked_p0) begin
      VGA_R     <= 1'b0;
      VGA_G     <= 1'b0;
      VGA_B     <= 1'b0;
      VGA_HS    <= 1'b0;
      VGA_VS    <= 1'b0;
      VGA_BLANK <= 1'b1;
    end else begin
      VGA_R     <= rgb_p0[0];
      VGA_G     <= rgb_p0[1];
      VGA_B     <= rgb_p0[2];
      VGA_HS    <= hs_p0;
      VGA_VS    <= vs_p0;
      VGA_BLANK <= blank_p0;
    end
  end

endmodule
